// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - packs a checked immediate into a RISC-V instruction word and buffers it for instruction-memory writes
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   request handshake; imm_src selects the format, imm is the
//                       value to place, base supplies all non-immediate bits
//   out_valid/out_ready output handshake from the 2-entry buffer head
//   out_instr, out_err  encoded word and its not-encodable flag
//   out_addr            word address for out_instr, advances per output handshake
//   err_count           saturating count of error words handed out
module imm_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int ADDR_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            imm_src,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] base,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_err,
    output logic [7:0]            err_count
);

    logic [DATA_WIDTH-1:0] field;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] enc;
    logic                  legal;

    // mask marks the immediate bit positions of the selected format; these
    // bits of base are always discarded, and only refilled when the value fits.
    always_comb begin
        field = '0;
        mask  = '0;
        legal = 1'b0;
        case (imm_src)
            3'b000, 3'b101: begin
                mask  = 32'hFFF0_0000;
                field = {imm[11:0], 20'b0};
                legal = (&imm[31:11]) | ~(|imm[31:11]);
            end
            3'b001: begin
                mask  = 32'hFE00_0F80;
                field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                legal = (&imm[31:11]) | ~(|imm[31:11]);
            end
            3'b010: begin
                mask  = 32'hFE00_0F80;
                field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                legal = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
            end
            3'b011: begin
                mask  = 32'hFFFF_F000;
                field = {imm[31:12], 12'b0};
                legal = ~(|imm[11:0]);
            end
            3'b100: begin
                mask  = 32'hFFFF_F000;
                field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                legal = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
            end
            default: begin
                // reserved formats: no field to clear, base passes through
                mask  = '0;
                field = '0;
                legal = 1'b0;
            end
        endcase
        enc = (base & ~mask) | (legal ? field : '0);
    end

    logic [DATA_WIDTH-1:0] mem_instr [2];
    logic                  mem_err   [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;

    // in_ready looks only at the registered count, never at out_ready
    assign in_ready  = ~rst & (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_err   = out_valid & mem_err[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_instr[i] <= '0;
                mem_err[i]   <= 1'b0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            out_addr  <= ADDR_WIDTH'(ADDR_BASE);
            err_count <= 8'd0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= enc;
                mem_err[wr_ptr]   <= ~legal;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                out_addr <= out_addr + ADDR_WIDTH'(1);
                if (mem_err[rd_ptr] && (err_count != 8'hFF))
                    err_count <= err_count + 8'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
